// File: rtl/pixie_fb_arbiter_pkg.sv
// Shared constants and CPU FSM encoding for the
// Pixie framebuffer arbiter.
package pixie_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int FB_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_PEND = 2'd1,
    CPU_DONE = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/pixie_fb_arbiter_if.sv
// CPU/DMA request bus into the framebuffer arbiter.
// master = bus glue, slave = arbiter.
interface pixie_fb_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata
  );

endinterface

// File: rtl/pixie_fb_clear.sv
// Clear engine: single-pass fill counter with
// busy/done status, advanced only on granted slots.
module pixie_fb_clear #(
  parameter int ADDR_W = pixie_pkg::ADDR_W,
  parameter int DATA_W = pixie_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              grant_clear,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] fill
);

  import pixie_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      addr <= '0;
      fill <= '0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        busy <= 1'b1;
        addr <= '0;
        fill <= value;
      end else if (busy && grant_clear) begin
        // stop on the last address; never wrap
        if (addr == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixie_fb_arbiter.sv
// Framebuffer port arbiter: display > CPU > clear,
// chosen combinationally every cycle.
module pixie_fb_arbiter #(
  parameter int ADDR_W = pixie_pkg::ADDR_W,
  parameter int DATA_W = pixie_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_rd_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  pixie_fb_arbiter_if.slave cpu,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import pixie_pkg::*;

  cpu_state_t        state;
  cpu_state_t        state_nxt;

  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;

  logic              grant_disp;
  logic              grant_cpu;
  logic              grant_clear;
  logic              accept;

  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_fill;

  // a request seen during its own ack cycle is
  // the old one, not a new access
  assign accept = (state == CPU_IDLE)
                & cpu.cpu_req & ~ack_q;

  always_ff @(posedge clk) begin
    if (reset) state <= CPU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CPU_IDLE: if (accept)      state_nxt = CPU_PEND;
      CPU_PEND: if (!disp_rd_en) state_nxt = CPU_DONE;
      CPU_DONE:                  state_nxt = CPU_IDLE;
      default:                   state_nxt = CPU_IDLE;
    endcase
  end

  always_comb begin
    grant_disp  = ~reset & disp_rd_en;
    grant_cpu   = ~reset & ~disp_rd_en
                & (state == CPU_PEND);
    grant_clear = ~reset & ~disp_rd_en
                & ~grant_cpu & clear_busy;
    ram_addr    = addr_q;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    unique case (1'b1)
      grant_disp: begin
        ram_addr = disp_addr;
      end
      grant_cpu: begin
        ram_addr  = hold_addr;
        ram_we    = hold_we;
        ram_wdata = hold_wdata;
      end
      grant_clear: begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
    end else begin
      ack_q  <= (state == CPU_DONE);
      addr_q <= ram_addr;
      if (accept) begin
        hold_we    <= cpu.cpu_we;
        hold_addr  <= cpu.cpu_addr;
        hold_wdata <= cpu.cpu_wdata;
      end
      if (state == CPU_DONE && !hold_we)
        rdata_q <= ram_rdata;
    end
  end

  pixie_fb_clear #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_clear (
    .clk         (clk),
    .reset       (reset),
    .start       (clear_start),
    .value       (clear_value),
    .grant_clear (grant_clear),
    .busy        (clear_busy),
    .done        (clear_done),
    .addr        (clr_addr),
    .fill        (clr_fill)
  );

  assign disp_data     = ram_rdata;
  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_pixie_fb_arbiter.sv
// Bench for pixie_fb_arbiter: RAM model, table
// vectors, random traffic and clear/reset sequences.
module tb_pixie_fb_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_init;
  logic       disp_rd_en;
  logic [9:0] disp_addr;
  logic [7:0] disp_data;
  logic       clear_start;
  logic [7:0] clear_value;
  logic       clear_busy;
  logic       clear_done;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] last_rd;

  pixie_fb_arbiter_if #(
    .ADDR_W(10), .DATA_W(8)
  ) cpu_bus ();

  pixie_fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .disp_rd_en  (disp_rd_en),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .cpu         (cpu_bus),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         doff;
    logic [9:0] daddr;
    int         lat;
  } vec_t;

  vec_t vecs [7];

  task automatic txn(input logic       we,
                     input logic [9:0] addr,
                     input logic [7:0] wd,
                     input int         doff,
                     input logic [9:0] daddr,
                     input int         exp_lat);
    int lat;
    int iss;
    logic [7:0] rd;
    lat = -1;
    iss = -1;
    rd  = '0;
    @(posedge clk); #1;
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = wd;
    for (int c = 0; c < 12; c++) begin
      if (doff >= 0) begin
        disp_rd_en = (c == doff);
        disp_addr  = daddr;
      end
      @(negedge clk);
      if (doff >= 0 && c == doff)
        check("disp_slot", int'({ram_we, ram_addr}),
              int'({1'b0, daddr}));
      if (doff >= 0 && c == doff + 1)
        check("disp_data", int'(disp_data),
              int'(ref_mem[daddr]));
      if (iss < 0 && c >= 1 && !disp_rd_en &&
          ram_addr == addr && ram_we == we &&
          (!we || ram_wdata == wd))
        iss = c;
      if (cpu_bus.cpu_ack) begin
        lat = c;
        rd  = cpu_bus.cpu_rdata;
        cpu_bus.cpu_req = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (doff >= 0) disp_rd_en = 1'b0;
    if (lat < 0) begin
      tests++;
      fails++;
      cpu_bus.cpu_req = 1'b0;
      $display("FAIL ack_timeout: addr %0h", addr);
    end else begin
      if (exp_lat > 0)
        check("ack_latency", lat, exp_lat);
      else
        check("ack_latency_le4",
              int'(lat >= 3 && lat <= 4), 1);
      check("issue_cycle", iss, lat - 2);
      if (we) begin
        check("rdata_hold", int'(rd), int'(last_rd));
        ref_mem[addr] = wd;
      end else begin
        check("rdata", int'(rd), int'(ref_mem[addr]));
        last_rd = rd;
      end
    end
  endtask

  task automatic disp_proc(input int n);
    logic [9:0] a;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      a = 10'($urandom_range(0, 255));
      disp_rd_en = 1'b1;
      disp_addr  = a;
      @(posedge clk); #1;
      disp_rd_en = 1'b0;
      @(negedge clk);
      check("rand_disp_data", int'(disp_data),
            int'(ref_mem[a]));
      repeat (6) @(posedge clk);
    end
  endtask

  task automatic start_clear(input logic [7:0] v);
    @(posedge clk); #1;
    clear_value = v;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (clear_done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("clear_done_seen", int'(seen), 1);
  endtask

  initial begin
    int nwr;
    int ndone;
    int done_c;
    int nack;
    bit wr_ok;
    bit busy1;

    reset             = 1'b1;
    mem_init          = 1'b1;
    disp_rd_en        = 1'b0;
    disp_addr         = '0;
    clear_start       = 1'b0;
    clear_value       = '0;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;
    last_rd           = '0;
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 8'(i * 7 + 3);

    vecs[0] = '{1'b1, 10'h123, 8'h5A, -1, 10'h000, 3};
    vecs[1] = '{1'b0, 10'h123, 8'h00,  1, 10'h040, 4};
    vecs[2] = '{1'b0, 10'h123, 8'h00, -1, 10'h000, 3};
    vecs[3] = '{1'b1, 10'h2AA, 8'h33,  0, 10'h010, 3};
    vecs[4] = '{1'b1, 10'h001, 8'h77,  2, 10'h123, 3};
    vecs[5] = '{1'b0, 10'h001, 8'h00,  1, 10'h2AA, 4};
    vecs[6] = '{1'b0, 10'h3FF, 8'h00, -1, 10'h000, 3};

    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    check("rst_ack", int'(cpu_bus.cpu_ack), 0);
    check("rst_rdata", int'(cpu_bus.cpu_rdata), 0);
    check("rst_busy", int'(clear_busy), 0);
    check("rst_done", int'(clear_done), 0);
    check("rst_we", int'(ram_we), 0);
    check("rst_addr", int'(ram_addr), 0);

    foreach (vecs[i])
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata,
          vecs[i].doff, vecs[i].daddr, vecs[i].lat);

    fork
      disp_proc(40);
      begin
        for (int i = 0; i < 50; i++) begin
          logic w;
          logic [9:0] a;
          w = 1'($urandom_range(0, 1));
          a = w ? 10'($urandom_range(256, 1023))
                : 10'($urandom_range(0, 1023));
          txn(w, a, 8'($urandom), -1, 10'h0, -1);
        end
      end
    join
    disp_rd_en = 1'b0;

    @(posedge clk); #1;
    clear_value = 8'hFF;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    nwr    = 0;
    ndone  = 0;
    done_c = -1;
    wr_ok  = 1'b1;
    busy1  = 1'b0;
    for (int c = 1; c <= 1030; c++) begin
      clear_start = (c == 1024);
      clear_value = (c == 1024) ? 8'h00 : 8'hFF;
      @(negedge clk);
      if (c == 1) busy1 = clear_busy;
      if (ram_we) begin
        if (ram_addr != 10'(nwr) ||
            ram_wdata != 8'hFF)
          wr_ok = 1'b0;
        nwr++;
      end
      if (clear_done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      @(posedge clk); #1;
    end
    clear_start = 1'b0;
    check("clr_busy_start", int'(busy1), 1);
    check("clr_nwrites", nwr, 1024);
    check("clr_seq", int'(wr_ok), 1);
    check("clr_done_cycle", done_c, 1025);
    check("clr_done_pulses", ndone, 1);
    check("clr_busy_end", int'(clear_busy), 0);
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 8'hFF;
    txn(1'b0, 10'h3FF, 8'h00, -1, 10'h0, 3);

    start_clear(8'h3C);
    txn(1'b1, 10'h200, 8'h11, -1, 10'h0, 3);
    wait_done(1200);
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 8'h3C;
    txn(1'b0, 10'h200, 8'h00, -1, 10'h0, 3);

    start_clear(8'h5C);
    repeat (10'h240) @(posedge clk);
    txn(1'b1, 10'h200, 8'h11, -1, 10'h0, 3);
    wait_done(1200);
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 8'h5C;
    ref_mem[10'h200] = 8'h11;
    txn(1'b0, 10'h200, 8'h00, -1, 10'h0, 3);
    txn(1'b0, 10'h1FF, 8'h00, -1, 10'h0, 3);

    start_clear(8'h99);
    repeat (50) @(posedge clk);
    #1;
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = 1'b1;
    cpu_bus.cpu_addr  = 10'h050;
    cpu_bus.cpu_wdata = 8'hAA;
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rst_pend_we", int'(ram_we), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_busy", int'(clear_busy), 0);
    check("rst2_ack", int'(cpu_bus.cpu_ack), 0);
    check("rst2_we", int'(ram_we), 0);
    check("rst2_addr", int'(ram_addr), 0);
    nack  = 0;
    ndone = 0;
    nwr   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_bus.cpu_ack) nack++;
      if (clear_done) ndone++;
      if (ram_we) nwr++;
    end
    check("rst2_no_ack", nack, 0);
    check("rst2_no_done", ndone, 0);
    check("rst2_no_we", nwr, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
